// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: serialiser state encoding, frame layout and frame builder.
// Intended for reuse by both device-side and host-side PS/2 blocks.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_GAP  = 2'd3
  } ps2_state_t;

  localparam int   PS2_FRAME_BITS = 11;
  localparam logic PS2_START_BIT  = 1'b0;
  localparam logic PS2_STOP_BIT   = 1'b1;

  // Frame bit 0 is transmitted first: start, data LSB..MSB, odd parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
    return {PS2_STOP_BIT, ~^data, data, PS2_START_BIT};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the PS/2 serialiser.
// DEPTH must be a power of two so the pointers wrap naturally.
module ps2_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: queues scan-code bytes and sends them as
// 11-bit frames with registered ps2_clk/ps2_data and an idle gap after each frame.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP     = 8,
  parameter int DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam int CNT_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int AW      = $clog2(DEPTH);

  localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);
  localparam logic [3:0]    LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  ps2_state_t                state;
  ps2_state_t                state_nxt;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             cnt_nxt;
  logic [3:0]                bitidx;
  logic [3:0]                bitidx_nxt;
  logic [PS2_FRAME_BITS-1:0] shreg;
  logic [PS2_FRAME_BITS-1:0] shreg_nxt;
  logic                      ps2_clk_nxt;
  logic                      ps2_data_nxt;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic [7:0]                fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [AW:0]               fifo_count;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);

  ps2_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // State, phase timer, bit index, shift register and registered line drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bitidx   <= 4'd0;
      shreg    <= '1;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bitidx   <= bitidx_nxt;
      shreg    <= shreg_nxt;
      ps2_clk  <= ps2_clk_nxt;
      ps2_data <= ps2_data_nxt;
    end
  end

  // Next-state logic; data only moves in HIGH, so LOW always holds the last driven bit.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bitidx_nxt   = bitidx;
    shreg_nxt    = shreg;
    fifo_pop     = 1'b0;
    ps2_clk_nxt  = 1'b1;
    ps2_data_nxt = 1'b1;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_nxt  = ps2_frame(fifo_head);
          cnt_nxt    = DIV_LOAD;
          bitidx_nxt = 4'd0;
          state_nxt  = ST_HIGH;
        end else begin
          state_nxt  = ST_IDLE;
        end
      end

      ST_HIGH: begin
        ps2_clk_nxt  = 1'b1;
        ps2_data_nxt = shreg[0];
        if (cnt == '0) begin
          cnt_nxt   = DIV_LOAD;
          state_nxt = ST_LOW;
        end else begin
          cnt_nxt   = cnt - CW'(1);
        end
      end

      ST_LOW: begin
        ps2_clk_nxt  = 1'b0;
        ps2_data_nxt = ps2_data;
        if (cnt == '0) begin
          if (bitidx == LAST_BIT) begin
            cnt_nxt   = GAP_LOAD;
            state_nxt = ST_GAP;
          end else begin
            bitidx_nxt = bitidx + 4'd1;
            shreg_nxt  = {PS2_STOP_BIT, shreg[PS2_FRAME_BITS-1:1]};
            cnt_nxt    = DIV_LOAD;
            state_nxt  = ST_HIGH;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      ST_GAP: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt   = cnt - CW'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed testbench for ps2_kbd_tx: a line monitor decodes frames and checks phase
// timing and data stability, while scenario tasks compare against hand-computed values.
module tb_ps2_kbd_tx;

  localparam int CLK_DIV = 4;
  localparam int GAP     = 8;
  localparam int DEPTH   = 4;
  localparam int PITCH   = 22*CLK_DIV + GAP + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int          cyc = 0;
  int          fall_cnt = 0;
  logic [10:0] frames[$];
  int          frame_cyc[$];

  ps2_kbd_tx #(
    .CLK_DIV (CLK_DIV),
    .GAP     (GAP),
    .DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // Line monitor: decodes frames on ps2_clk falling edges and times every phase.
  initial begin
    logic        prev_clk;
    logic        prev_data;
    int          run;
    int          bitcnt;
    int          fstart;
    bit          after_rise;
    bit          skip;
    logic [10:0] sh;
    prev_clk = 1'b1; prev_data = 1'b1; run = 0; bitcnt = 0; fstart = 0;
    after_rise = 1'b0; skip = 1'b0; sh = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        bitcnt = 0; after_rise = 1'b0; skip = 1'b1;
      end
      if (ps2_clk === 1'b0 && prev_clk === 1'b0) begin
        total++;
        if (ps2_data !== prev_data) begin
          bad++;
          $display("FAIL setup: ps2_data went %b -> %b while ps2_clk low (cycle %0d)", prev_data, ps2_data, cyc);
        end
      end
      if (ps2_clk !== prev_clk) begin
        if (ps2_clk === 1'b0) begin
          if (after_rise) begin
            total++;
            if (run != CLK_DIV) begin
              bad++;
              $display("FAIL high_phase: got %0d cycles, want %0d (cycle %0d)", run, CLK_DIV, cyc);
            end
          end
          if (bitcnt == 0) fstart = cyc;
          fall_cnt++;
          sh = {ps2_data, sh[10:1]};
          bitcnt++;
          skip = 1'b0;
          if (bitcnt == 11) begin
            frames.push_back(sh);
            frame_cyc.push_back(fstart);
            bitcnt = 0;
          end
          after_rise = 1'b0;
        end else begin
          if (!skip) begin
            total++;
            if (run != CLK_DIV) begin
              bad++;
              $display("FAIL low_phase: got %0d cycles, want %0d (cycle %0d)", run, CLK_DIV, cyc);
            end
          end
          skip = 1'b0;
          after_rise = (bitcnt != 0);
        end
        run = 1;
      end else begin
        run++;
      end
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", name, busy, n);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL send_timeout: in_ready stayed %b for %0d cycles, want 1", in_ready, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 4;
    if (ps2_clk !== 1'b1)  begin bad++; $display("FAIL reset_clk: got %b want 1", ps2_clk); end
    if (ps2_data !== 1'b1) begin bad++; $display("FAIL reset_data: got %b want 1", ps2_data); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single_byte();
    int f0;
    int nf;
    int n;
    f0 = fall_cnt;
    nf = frames.size();
    @(negedge clk);
    in_data  = 8'h1C;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_after_push: got %b want 1", busy); end
    @(posedge clk); #1;
    total++;
    if (ps2_data !== 1'b1) begin bad++; $display("FAIL single_pop_cycle_data: got %b want 1", ps2_data); end
    @(posedge clk); #1;
    total += 2;
    if (ps2_data !== 1'b0) begin bad++; $display("FAIL single_start_bit: got %b want 0", ps2_data); end
    if (ps2_clk !== 1'b1)  begin bad++; $display("FAIL single_start_clk: got %b want 1", ps2_clk); end
    n = 2;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    total += 3;
    if (n != 97) begin bad++; $display("FAIL single_busy_len: busy fell %0d cycles after push, want 97", n); end
    if (fall_cnt - f0 != 11) begin bad++; $display("FAIL single_falls: got %0d falling edges, want 11", fall_cnt - f0); end
    if (frames.size() != nf + 1) begin
      bad++; $display("FAIL single_frame_count: got %0d frames, want %0d", frames.size() - nf, 1);
    end else begin
      total++;
      if (frames[nf] !== 11'h438) begin bad++; $display("FAIL single_bits: got %h want 438", frames[nf]); end
    end
  endtask

  task automatic test_parity();
    int nf;
    logic [10:0] exp [3];
    exp[0] = 11'h7FE;  // 0xFF: parity 1
    exp[1] = 11'h402;  // 0x01: parity 0
    exp[2] = 11'h600;  // 0x00: parity 1
    nf = frames.size();
    send_byte(8'hFF);
    send_byte(8'h01);
    send_byte(8'h00);
    wait_idle(1000, "parity");
    total++;
    if (frames.size() != nf + 3) begin
      bad++; $display("FAIL parity_count: got %0d frames want 3", frames.size() - nf);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (frames[nf+i] !== exp[i]) begin bad++; $display("FAIL parity_frame%0d: got %h want %h", i, frames[nf+i], exp[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        total++;
        if (frame_cyc[nf+i] - frame_cyc[nf+i-1] != PITCH) begin
          bad++; $display("FAIL parity_pitch%0d: got %0d want %0d", i, frame_cyc[nf+i] - frame_cyc[nf+i-1], PITCH);
        end
      end
    end
  endtask

  task automatic test_fifo_fill();
    int nf;
    logic rdy [6];
    logic [7:0] b;
    nf = frames.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b = 8'hA0 + 8'(i);
      in_data  = b;
      in_valid = 1'b1;
      rdy[i]   = in_ready;
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (rdy[i] !== (i < 5 ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL fill_ready%0d: got %b want %b", i, rdy[i], (i < 5 ? 1'b1 : 1'b0));
      end
    end
    wait_idle(2000, "fill");
    total++;
    if (frames.size() != nf + 5) begin
      bad++; $display("FAIL fill_count: got %0d frames want 5", frames.size() - nf);
    end else begin
      for (int i = 0; i < 5; i++) begin
        b = 8'hA0 + 8'(i);
        total++;
        if (frames[nf+i] !== exp_frame(b)) begin bad++; $display("FAIL fill_frame%0d: got %h want %h", i, frames[nf+i], exp_frame(b)); end
        if (i > 0) begin
          total++;
          if (frame_cyc[nf+i] - frame_cyc[nf+i-1] != PITCH) begin
            bad++; $display("FAIL fill_pitch%0d: got %0d want %0d", i, frame_cyc[nf+i] - frame_cyc[nf+i-1], PITCH);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    int nf;
    int n;
    f0 = fall_cnt;
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    n = 0;
    while (fall_cnt - f0 < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (fall_cnt - f0 < 5) begin bad++; $display("FAIL midrst_wait: got %0d falls want 5", fall_cnt - f0); end
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2;
    total += 4;
    if (ps2_clk !== 1'b1)  begin bad++; $display("FAIL midrst_clk: got %b want 1", ps2_clk); end
    if (ps2_data !== 1'b1) begin bad++; $display("FAIL midrst_data: got %b want 1", ps2_data); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    f0 = fall_cnt;
    nf = frames.size();
    repeat (300) @(negedge clk);
    total += 3;
    if (fall_cnt != f0)      begin bad++; $display("FAIL midrst_falls: got %0d extra falls want 0", fall_cnt - f0); end
    if (frames.size() != nf) begin bad++; $display("FAIL midrst_frames: got %0d extra frames want 0", frames.size() - nf); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL midrst_busy_later: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int nf;
    logic [7:0] sent[$];
    logic [7:0] b;
    nf = frames.size();
    for (int i = 0; i < 200; i++) begin
      b = 8'($urandom_range(0, 255));
      sent.push_back(b);
      send_byte(b);
    end
    wait_idle(PITCH * 10, "stream");
    total++;
    if (frames.size() != nf + 200) begin
      bad++; $display("FAIL stream_count: got %0d frames want 200", frames.size() - nf);
    end else begin
      for (int i = 0; i < 200; i++) begin
        total++;
        if (frames[nf+i] !== exp_frame(sent[i])) begin
          bad++; $display("FAIL stream_frame%0d: got %h want %h", i, frames[nf+i], exp_frame(sent[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_parity();
    test_fifo_fill();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

Device-side PS/2 keyboard transmitter: serialises queued scan-code bytes into standard 11-bit PS/2 frames on `ps2_clk`/`ps2_data`. It is the other end of the `ps2_keyboard` receiver, and lets simulation drive the keyboard path in `top` without a physical keyboard. Bytes enter through a valid/ready handshake into a small FIFO and are sent back to back, with a mandatory idle gap between frames.

## Interface
- `CLK_DIV`, default 4: system cycles per PS/2 clock half-period; must be ≥2.
- `GAP`, default 8: system cycles of idle (both lines high) after each stop bit; must be ≥1.
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥2.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_data` input, 8 bits: scan-code byte to queue.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: FIFO can accept a byte; equals !full.
- `ps2_clk` output, 1 bit: PS/2 clock, registered; idles high.
- `ps2_data` output, 1 bit: PS/2 data, registered; idles high.
- `busy` output, 1 bit: a frame or gap is in progress, or the FIFO is non-empty.

## Operation
- Push occurs when `in_valid && in_ready`. Otherwise `in_data` is ignored. No overflow is possible.
- Frame bit order:
  - bit 0: start, value 0
  - bits 1–8: data, LSB first
  - bit 9: odd parity, `~^data`
  - bit 10: stop, value 1
- FSM states IDLE, HIGH, LOW, GAP. A down-counter `cnt` times each phase, and `bitidx` runs 0..10.
- IDLE: if the FIFO is non-empty, pop the head into an 11-bit shift register, load `cnt=CLK_DIV-1`, set `bitidx=0`, then go to HIGH. Otherwise stay in IDLE.
- HIGH: `ps2_clk=1`, `ps2_data`=current bit. When `cnt=0`, go to LOW and reload `cnt`.
- LOW: `ps2_clk=0` and `ps2_data` is held. When `cnt=0`:
  - if `bitidx=10`, go to GAP with `cnt=GAP-1`;
  - otherwise increment `bitidx`, shift, go to HIGH, and reload `cnt`.
- GAP: both lines are 1. When `cnt=0`, go to IDLE.
- `ps2_data` changes only at the LOW→HIGH boundary, or on entry to HIGH from IDLE. It is never changed while `ps2_clk=0`, so the receiver sees CLK_DIV cycles of setup before each falling edge.
- Push and pop in the same cycle are both performed and the count is unchanged. On a full FIFO no push occurs, because `in_ready=0`.
- Pointers wrap modulo DEPTH. Count is `$clog2(DEPTH)+1` bits wide.

## Timing
- Reset values: `ps2_clk=1`, `ps2_data=1`, `busy=0`, `in_ready=1`. State is IDLE and the FIFO is flushed.
- Reset asserted mid-frame aborts the frame. Both lines are high on the cycle after the reset edge, and the queued bytes are discarded.
- Latency: a byte pushed at edge N into an empty FIFO while in IDLE is popped at N+1. `ps2_data=0` (start bit) is visible after edge N+2, with `ps2_clk` still high.
- The frame occupies 22·CLK_DIV cycles, followed by GAP cycles. Every PS/2 clock period is exactly 2·CLK_DIV cycles.
- Frame pitch for queued bytes is 22·CLK_DIV+GAP+1 cycles; the +1 is the IDLE pop cycle.
- `busy` is combinational: (state≠IDLE) || (count≠0). It deasserts the cycle after GAP expires when the FIFO is empty.
- `in_ready` is combinational from count and has no dependence on `in_valid`.

## Structure
- Package `ps2_pkg` holds:
  - the state encoding (IDLE/HIGH/LOW/GAP);
  - `PS2_FRAME_BITS=11`;
  - the start and stop bit constants.
- The package is shared with any future host-side PS/2 block.
- The FIFO is a separate sub-module, `ps2_tx_fifo`: synchronous, first-word-fall-through, DEPTH-parameterised, with push/pop/full/empty/count ports. The serialiser FSM lives in `ps2_kbd_tx`.

## Test plan
- **Single byte** (CLK_DIV=4, GAP=8): push 0x1C once. Sampling `ps2_data` at each `ps2_clk` falling edge gives 0,0,0,1,1,1,0,0,0,0,1. There are exactly 11 falling edges, each low phase is 4 cycles, and `busy` drops 8+ cycles after the stop bit.
- **Parity:** 0xFF gives parity bit 1, 0x01 gives parity bit 0, and 0x00 gives parity bit 1.
- **FIFO fill:** from idle, assert `in_valid` for 6 consecutive cycles with bytes A–F. A–E are accepted and `in_ready=0` on the 6th cycle. The 5 frames then appear in order A–E with pitch 22·CLK_DIV+GAP+1.
- **Loopback:** connect to `ps2_keyboard` (`resetn=~rst`) and send the sequence 0x1C, 0xF0, 0x1C. The receiver reports the same three bytes in order with no parity or framing error.
- **Reset mid-frame:** assert `rst` during bit 5 with 2 bytes queued. The next cycle shows `ps2_clk=1`, `ps2_data=1`, `busy=0`, `in_ready=1`, and no further falling edges occur.
- **Setup check:** an assertion confirms `ps2_data` never changes while `ps2_clk=0`, and that `ps2_clk` high and low phases are each exactly CLK_DIV cycles, across a random 200-byte stream.
